// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and constants for the SPI-slave register controller
//   reg_ctrl_state_e : command sequencer states
//   OP_WRITE/OP_READ : command[7:4] opcodes; REG_ADDR_W : register address width
package spi_slave_pkg;
    localparam logic [3:0] OP_WRITE   = 4'h1;
    localparam logic [3:0] OP_READ    = 4'h2;
    localparam int         REG_ADDR_W = 2;
    typedef enum logic [2:0] {IDLE, WRITE, RLOAD, RWAIT, IGNORE} reg_ctrl_state_e;
endpackage

// File: rtl/spi_slave_reg_ctrl.sv
// spi_slave_reg_ctrl: sclk-domain command sequencer between SPI RX/TX shifters and the config register file
//   sclk_i/rstn_i          : clock, async active-low reset
//   cs_i                   : transaction active; low aborts any burst
//   rx_data_i/rx_valid_i   : byte from RX shifter with 1-cycle valid pulse
//   wr_data_o/wr_addr_o/wr_data_valid_o : registered register-write port, 1-cycle strobe
//   rd_addr_o/rd_data_i    : register read port (rd_data_i combinational from rd_addr_o)
//   tx_data_o/tx_valid_o/tx_ready_i : byte to TX shifter, valid held until ready
//   busy_o                 : sequencer not idle
module spi_slave_reg_ctrl
    import spi_slave_pkg::*;
#(
    parameter int REG_SIZE = 8
) (
    input  logic                  sclk_i,
    input  logic                  rstn_i,
    input  logic                  cs_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic [REG_SIZE-1:0]   wr_data_o,
    output logic [REG_ADDR_W-1:0] wr_addr_o,
    output logic                  wr_data_valid_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    input  logic [REG_SIZE-1:0]   rd_data_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o
);
    reg_ctrl_state_e       state_q, state_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [REG_SIZE-1:0]   wr_data_q, wr_data_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  wr_valid_q, wr_valid_d, tx_valid_q, tx_valid_d, busy_q;

    always_ff @(posedge sclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= state_d != IDLE;
        end
    end

    // cs low overrides everything; a strobe already in wr_valid_q still completes
    // because the default only clears the next cycle's strobe.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (!cs_i) begin
            state_d    = IDLE;
            addr_d     = '0;
            tx_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (rx_valid_i) begin
                    addr_d  = rx_data_i[1:0];
                    state_d = rx_data_i[7:4] == OP_WRITE ? WRITE :
                              rx_data_i[7:4] == OP_READ  ? RLOAD : IGNORE;
                end
                WRITE: if (rx_valid_i) begin
                    wr_addr_d  = addr_q;
                    wr_data_d  = rx_data_i;
                    wr_valid_d = 1'b1;
                    addr_d     = addr_q + 1'b1;
                end
                RLOAD: begin
                    tx_data_d  = rd_data_i[7:0];
                    tx_valid_d = 1'b1;
                    state_d    = RWAIT;
                end
                RWAIT: if (tx_valid_q && tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    addr_d     = addr_q + 1'b1;
                    state_d    = RLOAD;
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign wr_data_o       = wr_data_q;
    assign wr_addr_o       = wr_addr_q;
    assign wr_data_valid_o = wr_valid_q;
    assign rd_addr_o       = addr_q;
    assign tx_data_o       = tx_data_q;
    assign tx_valid_o      = tx_valid_q;
    assign busy_o          = busy_q;
endmodule
